mem_stage_ctrl: RTL and testbench



---
 rtl/mem_stage_ctrl.sv | 101 ++++++++++
 tb/tb_mem_stage_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// Memory-stage data-memory controller: word loads/stores on a local RAM
// with a fixed number of wait states, stalling the pipeline while busy.
module mem_stage_ctrl #(
   parameter int WORD_WIDTH  = 32,
   parameter int DEPTH       = 64,
   parameter int BASE_ADDR   = 1024,
   parameter int WAIT_CYCLES = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_r_en,
   input  logic                  mem_w_en,
   input  logic [WORD_WIDTH-1:0] alu_res,
   input  logic [WORD_WIDTH-1:0] st_val,
   output logic                  freeze,
   output logic                  ready,
   output logic [WORD_WIDTH-1:0] mem_result,
   output logic                  addr_err
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [WORD_WIDTH-1:0] BASE = WORD_WIDTH'(BASE_ADDR);
   localparam logic [WORD_WIDTH-1:0] SPAN = WORD_WIDTH'(4 * DEPTH);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                state;
   logic [3:0]            counter;
   logic [WORD_WIDTH-1:0] cap_addr;
   logic [WORD_WIDTH-1:0] cap_data;
   logic                  cap_store;
   logic [WORD_WIDTH-1:0] mem [DEPTH];

   logic                  req;
   logic [WORD_WIDTH-1:0] off;
   logic [IDX_W-1:0]      index;
   logic                  in_range;

   // Decode works on the captured address so mid-access input changes are ignored;
   // the range test uses the full offset so out-of-range addresses never alias.
   assign req      = mem_r_en | mem_w_en;
   assign off      = cap_addr - BASE;
   assign index    = off[IDX_W+1:2];
   assign in_range = (cap_addr >= BASE) && (off < SPAN);

   // Upstream stalls from the request cycle through the last wait state.
   assign freeze = (state == BUSY) || ((state == IDLE) && req);

   // Access sequencer: capture on request, count wait states, then perform the access.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         counter    <= '0;
         ready      <= 1'b0;
         mem_result <= '0;
         addr_err   <= 1'b0;
         cap_addr   <= '0;
         cap_data   <= '0;
         cap_store  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         ready <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  cap_addr  <= alu_res;
                  cap_data  <= st_val;
                  cap_store <= mem_w_en;
                  counter   <= 4'(WAIT_CYCLES - 1);
                  state     <= BUSY;
               end
            end
            BUSY: begin
               if (counter == 4'd0) begin
                  if (cap_store) begin
                     if (in_range) begin
                        mem[index] <= cap_data;
                     end
                  end else begin
                     mem_result <= in_range ? mem[index] : '0;
                  end
                  addr_err <= ~in_range;
                  ready    <= 1'b1;
                  state    <= DONE;
               end else begin
                  counter <= counter - 4'd1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed testbench for mem_stage_ctrl with default parameters
// (BASE 1024, 64 words, 3 wait states).
module tb_mem_stage_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_r_en;
   logic        mem_w_en;
   logic [31:0] alu_res;
   logic [31:0] st_val;
   logic        freeze;
   logic        ready;
   logic [31:0] mem_result;
   logic        addr_err;

   int tests_run    = 0;
   int tests_failed = 0;

   mem_stage_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .mem_r_en   (mem_r_en),
      .mem_w_en   (mem_w_en),
      .alu_res    (alu_res),
      .st_val     (st_val),
      .freeze     (freeze),
      .ready      (ready),
      .mem_result (mem_result),
      .addr_err   (addr_err)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Issue one access at the next falling edge and observe it until ready.
   // fz counts cycles with freeze high before ready; rdy_at is the cycle index
   // (0 = request cycle) where ready was seen, or -1 if it never came.
   task automatic run_access(input logic r, input logic w, input logic [31:0] a,
                             input logic [31:0] d, output int fz, output int rdy_at,
                             output logic [31:0] res, output logic err);
      fz     = 0;
      rdy_at = -1;
      res    = '0;
      err    = 1'b0;
      @(negedge clk);
      mem_r_en = r;
      mem_w_en = w;
      alu_res  = a;
      st_val   = d;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (ready === 1'b1) begin
            rdy_at = i;
            res    = mem_result;
            err    = addr_err;
            break;
         end
         if (freeze === 1'b1) fz++;
         @(negedge clk);
      end
      mem_r_en = 1'b0;
      mem_w_en = 1'b0;
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      mem_r_en = 1'b0;
      mem_w_en = 1'b0;
      alu_res  = 32'd1024;
      st_val   = 32'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      tests_run++;
      if (freeze !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_freeze got %b want 0", freeze); end
      tests_run++;
      if (ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ready got %b want 0", ready); end
      tests_run++;
      if (mem_result !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_result got %h want 0", mem_result); end
      tests_run++;
      if (addr_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err got %b want 0", addr_err); end
   endtask

   task automatic test_no_request();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         alu_res = 32'd1024 + 32'(4 * i);
         st_val  = 32'(i);
         #1;
         tests_run++;
         if (freeze !== 1'b0 || ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL idle_no_freeze cycle %0d got freeze=%b ready=%b want 0/0", i, freeze, ready);
         end
      end
   endtask

   task automatic test_store_load();
      int fz, rdy; logic [31:0] res; logic err;
      run_access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, fz, rdy, res, err);
      tests_run++;
      if (fz !== 4) begin tests_failed++; $display("[TB] FAIL str_freeze_cycles got %0d want 4", fz); end
      tests_run++;
      if (rdy !== 4) begin tests_failed++; $display("[TB] FAIL str_ready_cycle got %0d want 4", rdy); end
      tests_run++;
      if (err !== 1'b0) begin tests_failed++; $display("[TB] FAIL str_err got %b want 0", err); end
      @(negedge clk);
      #1;
      tests_run++;
      if (ready !== 1'b0 || freeze !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL ready_one_pulse got ready=%b freeze=%b want 0/0", ready, freeze);
      end
      run_access(1'b1, 1'b0, 32'd1032, 32'h0, fz, rdy, res, err);
      tests_run++;
      if (res !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL ldr_1032 got %h want deadbeef", res); end
      tests_run++;
      if (err !== 1'b0 || fz !== 4 || rdy !== 4) begin
         tests_failed++;
         $display("[TB] FAIL ldr_timing got err=%b fz=%0d rdy=%0d want 0/4/4", err, fz, rdy);
      end
      run_access(1'b1, 1'b0, 32'd1035, 32'h0, fz, rdy, res, err);
      tests_run++;
      if (res !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL ldr_unaligned got %h want deadbeef", res); end
   endtask

   task automatic test_boundaries();
      int fz, rdy; logic [31:0] res; logic err;
      run_access(1'b0, 1'b1, 32'd1024, 32'hA5A50001, fz, rdy, res, err);
      run_access(1'b0, 1'b1, 32'd1276, 32'hCAFEF00D, fz, rdy, res, err);
      run_access(1'b1, 1'b0, 32'd1276, 32'h0, fz, rdy, res, err);
      tests_run++;
      if (res !== 32'hCAFEF00D || err !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL ldr_last_word got %h err=%b want cafef00d err=0", res, err);
      end
      run_access(1'b1, 1'b0, 32'd1020, 32'h0, fz, rdy, res, err);
      tests_run++;
      if (res !== 32'h0 || err !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL ldr_below_base got %h err=%b want 0 err=1", res, err);
      end
      tests_run++;
      if (fz !== 4 || rdy !== 4) begin tests_failed++; $display("[TB] FAIL oor_latency got fz=%0d rdy=%0d want 4/4", fz, rdy); end
      repeat (2) @(negedge clk);
      #1;
      tests_run++;
      if (addr_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL err_sticky got %b want 1", addr_err); end
      run_access(1'b0, 1'b1, 32'd1280, 32'h00000BAD, fz, rdy, res, err);
      tests_run++;
      if (err !== 1'b1 || fz !== 4 || rdy !== 4) begin
         tests_failed++;
         $display("[TB] FAIL str_above_top got err=%b fz=%0d rdy=%0d want 1/4/4", err, fz, rdy);
      end
      run_access(1'b1, 1'b0, 32'd1024, 32'h0, fz, rdy, res, err);
      tests_run++;
      if (res !== 32'hA5A50001 || err !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL ldr_after_oor_str got %h err=%b want a5a50001 err=0", res, err);
      end
   endtask

   task automatic test_input_change();
      int fz, rdy; logic [31:0] res; logic err;
      fz  = 0;
      rdy = -1;
      res = '0;
      @(negedge clk);
      mem_r_en = 1'b1;
      mem_w_en = 1'b0;
      alu_res  = 32'd1024;
      st_val   = 32'h0;
      #1;
      if (freeze === 1'b1) fz++;
      @(negedge clk);
      alu_res  = 32'd1028;
      st_val   = 32'hFFFF0000;
      mem_w_en = 1'b1;
      for (int i = 1; i < 40; i++) begin
         #1;
         if (ready === 1'b1) begin
            rdy = i;
            res = mem_result;
            break;
         end
         if (freeze === 1'b1) fz++;
         @(negedge clk);
      end
      mem_r_en = 1'b0;
      mem_w_en = 1'b0;
      tests_run++;
      if (res !== 32'hA5A50001) begin tests_failed++; $display("[TB] FAIL busy_inputs_ignored got %h want a5a50001", res); end
      tests_run++;
      if (fz !== 4 || rdy !== 4) begin tests_failed++; $display("[TB] FAIL busy_latency got fz=%0d rdy=%0d want 4/4", fz, rdy); end
      run_access(1'b1, 1'b0, 32'd1028, 32'h0, fz, rdy, res, err);
      tests_run++;
      if (res !== 32'h0) begin tests_failed++; $display("[TB] FAIL busy_no_write got %h want 0", res); end
   endtask

   task automatic test_back_to_back();
      int fz, rdy; logic [31:0] res; logic err;
      run_access(1'b0, 1'b1, 32'd1040, 32'd5, fz, rdy, res, err);
      tests_run++;
      if (freeze !== 1'b0) begin tests_failed++; $display("[TB] FAIL done_freeze got %b want 0", freeze); end
      run_access(1'b1, 1'b0, 32'd1040, 32'h0, fz, rdy, res, err);
      tests_run++;
      if (fz !== 4 || rdy !== 4) begin tests_failed++; $display("[TB] FAIL b2b_no_bubble got fz=%0d rdy=%0d want 4/4", fz, rdy); end
      tests_run++;
      if (res !== 32'd5) begin tests_failed++; $display("[TB] FAIL b2b_data got %h want 5", res); end
   endtask

   task automatic test_reset_mid_store();
      int fz, rdy; logic [31:0] res; logic err;
      @(negedge clk);
      mem_w_en = 1'b1;
      mem_r_en = 1'b0;
      alu_res  = 32'd1044;
      st_val   = 32'h77;
      repeat (2) @(negedge clk);
      rst      = 1'b1;
      mem_w_en = 1'b0;
      @(negedge clk);
      #1;
      tests_run++;
      if (freeze !== 1'b0 || ready !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL midreset_outputs got freeze=%b ready=%b want 0/0", freeze, ready);
      end
      tests_run++;
      if (mem_result !== 32'h0) begin tests_failed++; $display("[TB] FAIL midreset_result got %h want 0", mem_result); end
      rst = 1'b0;
      run_access(1'b1, 1'b0, 32'd1044, 32'h0, fz, rdy, res, err);
      tests_run++;
      if (res !== 32'h0 || rdy !== 4) begin
         tests_failed++;
         $display("[TB] FAIL midreset_no_write got %h rdy=%0d want 0 rdy=4", res, rdy);
      end
      run_access(1'b1, 1'b0, 32'd1024, 32'h0, fz, rdy, res, err);
      tests_run++;
      if (res !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_clears_mem got %h want 0", res); end
   endtask

   task automatic test_both_enables();
      int fz, rdy; logic [31:0] res; logic err;
      run_access(1'b0, 1'b1, 32'd1032, 32'h11223344, fz, rdy, res, err);
      run_access(1'b1, 1'b0, 32'd1032, 32'h0, fz, rdy, res, err);
      tests_run++;
      if (res !== 32'h11223344) begin tests_failed++; $display("[TB] FAIL ldr_before_both got %h want 11223344", res); end
      run_access(1'b1, 1'b1, 32'd1048, 32'd9, fz, rdy, res, err);
      tests_run++;
      if (res !== 32'h11223344 || err !== 1'b0 || rdy !== 4) begin
         tests_failed++;
         $display("[TB] FAIL both_is_store got %h err=%b rdy=%0d want 11223344 err=0 rdy=4", res, err, rdy);
      end
      run_access(1'b1, 1'b0, 32'd1048, 32'h0, fz, rdy, res, err);
      tests_run++;
      if (res !== 32'd9) begin tests_failed++; $display("[TB] FAIL both_store_data got %h want 9", res); end
   endtask

   // Runs every scenario in order, then prints the summary.
   initial begin
      test_reset();
      test_no_request();
      test_store_load();
      test_boundaries();
      test_input_change();
      test_back_to_back();
      test_reset_mid_store();
      test_both_enables();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Guards against a stuck simulation.
   initial begin
      #50000;
      $display("[TB] FAIL watchdog timeout got running want finished");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
